mem_access_ctrl: RTL and testbench

// - MEM-stage data-cache access controller; sits between the EX/MEM register and the MEM/WB register.
// - Issues dcache read/write requests, including LL/SC with a link register.
// - Holds the pipeline until dhit, then presents the load/SC result and MEM/WB enable.
// - Keeps a sticky halt and a stall-cycle counter.

---
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage dcache access controller: LL/SC link register, sticky halt/misalign flags, stall counter.
// Same-cycle dhit completes with no stall; otherwise mem_stall holds until dhit, then DONE waits out ext_stall.
module mem_access_ctrl #(
   parameter int CNT_W     = 32,
   parameter int ALIGN_CHK = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             op_valid,
   input  logic             op_ren,
   input  logic             op_wen,
   input  logic             op_ll,
   input  logic             op_sc,
   input  logic             op_halt,
   input  logic [31:0]      op_addr,
   input  logic [31:0]      op_store,
   input  logic             ext_stall,
   input  logic             dhit,
   input  logic [31:0]      dmemload,
   input  logic             snoop_inv,
   input  logic [31:0]      snoop_addr,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic [31:0]      dmemaddr,
   output logic [31:0]      dmemstore,
   output logic [31:0]      mem_result,
   output logic             mem_stall,
   output logic             memwb_EN,
   output logic             halt_out,
   output logic             misalign_err,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_halt;
   logic             r_misalign;
   logic             r_link_valid;
   logic [29:0]      r_link_addr;
   logic [31:0]      r_result;
   logic [CNT_W-1:0] r_stall_cnt;

   logic        w_misaligned;
   logic        w_mem_op;
   logic        w_mis_op;
   logic        w_sc_ok;
   logic        w_sc_fail;
   logic        w_snoop_hit;
   logic        w_done;
   logic        w_mis;
   logic        w_ll_done;
   logic        w_sc_done;
   logic [31:0] w_hit_result;
   logic [31:0] w_result;
   logic        w_unused;

   assign w_misaligned = (ALIGN_CHK != 0) && (op_addr[1:0] != 2'b00);
   assign w_mem_op     = op_valid & (op_ren | op_wen) & ~r_halt & ~w_misaligned;
   assign w_mis_op     = op_valid & (op_ren | op_wen) & ~r_halt & w_misaligned;
   assign w_sc_ok      = r_link_valid & (r_link_addr == op_addr[31:2]);
   assign w_sc_fail    = op_wen & op_sc & ~w_sc_ok;
   assign w_snoop_hit  = snoop_inv & r_link_valid & (snoop_addr[31:2] == r_link_addr);
   assign w_hit_result = op_ren ? dmemload : {31'd0, op_sc & w_sc_ok};
   assign w_ll_done    = w_done & ~w_mis & op_ren & op_ll;
   assign w_sc_done    = w_done & ~w_mis & op_wen & op_sc;
   assign w_unused     = ^snoop_addr[1:0];

   assign dmemaddr     = op_addr;
   assign dmemstore    = op_store;
   assign halt_out     = r_halt;
   assign misalign_err = r_misalign;
   assign stall_cycles = r_stall_cnt;

   // Reset also gates the combinational outputs so an in-flight request drops without waiting for a clock.
   always_comb begin
      w_next     = r_state;
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      mem_stall  = 1'b0;
      memwb_EN   = 1'b0;
      mem_result = 32'd0;
      w_done     = 1'b0;
      w_mis      = 1'b0;
      w_result   = 32'd0;
      if (!RST) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_mem_op) begin
                  if (w_sc_fail) begin
                     w_done = 1'b1;
                  end else begin
                     dmemREN = op_ren;
                     dmemWEN = op_wen;
                     if (dhit) begin
                        w_done   = 1'b1;
                        w_result = w_hit_result;
                     end else begin
                        mem_stall = 1'b1;
                        w_next    = S_ACCESS;
                     end
                  end
               end else if (w_mis_op) begin
                  w_done = 1'b1;
                  w_mis  = 1'b1;
               end
            end
            S_ACCESS: begin
               // A snoop that kills the link turns an outstanding SC into a failed, request-free completion.
               if (w_sc_fail) begin
                  w_done = 1'b1;
               end else begin
                  dmemREN = op_ren;
                  dmemWEN = op_wen;
                  if (dhit) begin
                     w_done   = 1'b1;
                     w_result = w_hit_result;
                  end else begin
                     mem_stall = 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (!ext_stall) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
         if (w_done) w_next = ext_stall ? S_DONE : S_IDLE;
         mem_result = w_done ? w_result : r_result;
         memwb_EN   = ~mem_stall & ~ext_stall;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_halt       <= 1'b0;
         r_misalign   <= 1'b0;
         r_link_valid <= 1'b0;
         r_link_addr  <= 30'd0;
         r_result     <= 32'd0;
         r_stall_cnt  <= '0;
      end else begin
         r_state <= w_next;
         if (w_done) r_result <= w_result;
         if (w_mis) r_misalign <= 1'b1;
         if (op_halt && op_valid && !mem_stall) r_halt <= 1'b1;
         if (mem_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (w_ll_done) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= op_addr[31:2];
         end else if (w_sc_done || w_snoop_hit) begin
            r_link_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle comparison against a per-instruction model plus literal checks.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        op_valid = 0, op_ren = 0, op_wen = 0, op_ll = 0, op_sc = 0, op_halt = 0;
   logic [31:0] op_addr = 0, op_store = 0;
   logic        ext_stall = 0, dhit = 0, snoop_inv = 0;
   logic [31:0] dmemload = 0, snoop_addr = 0;
   logic        dmemREN, dmemWEN, mem_stall, memwb_EN, halt_out, misalign_err;
   logic [31:0] dmemaddr, dmemstore, mem_result, stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b1;
   int cnt_a;

   always #5 CLK = ~CLK;

   mem_access_ctrl #(.CNT_W(32), .ALIGN_CHK(1)) dut (
      .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_ren(op_ren), .op_wen(op_wen),
      .op_ll(op_ll), .op_sc(op_sc), .op_halt(op_halt), .op_addr(op_addr), .op_store(op_store),
      .ext_stall(ext_stall), .dhit(dhit), .dmemload(dmemload), .snoop_inv(snoop_inv),
      .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_result(mem_result), .mem_stall(mem_stall), .memwb_EN(memwb_EN),
      .halt_out(halt_out), .misalign_err(misalign_err), .stall_cycles(stall_cycles)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: an op in EX/MEM is either still owed a completion or already served.
   logic        m_served = 0, m_halt = 0, m_mis = 0, m_lv = 0;
   logic [31:0] m_la = 0, m_res = 0, m_cnt = 0;
   logic        e_ren, e_wen, e_stall, e_wb, e_done, e_mis, e_acc, e_ok;
   logic [31:0] e_res;

   always @(negedge CLK) begin
      if (mon_en) begin
         if (RST) begin
            chk("m_rst_ren", dmemREN, 0);
            chk("m_rst_wen", dmemWEN, 0);
            chk("m_rst_stall", mem_stall, 0);
            chk("m_rst_wb", memwb_EN, 0);
            chk("m_rst_res", mem_result, 0);
            chk("m_rst_halt", halt_out, 0);
            chk("m_rst_mis", misalign_err, 0);
            chk("m_rst_cnt", stall_cycles, 0);
            m_served = 0; m_halt = 0; m_mis = 0; m_lv = 0; m_la = 0; m_res = 0; m_cnt = 0;
         end else begin
            e_acc = op_valid && (op_ren || op_wen) && !m_halt;
            e_ok  = m_lv && (m_la[31:2] == op_addr[31:2]);
            e_ren = 0; e_wen = 0; e_stall = 0; e_done = 0; e_mis = 0; e_res = m_res;
            if (!m_served && e_acc) begin
               if (op_addr[1:0] != 2'b00) begin
                  e_done = 1; e_mis = 1; e_res = 0;
               end else if (op_wen && op_sc && !e_ok) begin
                  e_done = 1; e_res = 0;
               end else begin
                  e_ren = op_ren; e_wen = op_wen;
                  if (dhit) begin
                     e_done = 1;
                     e_res  = op_ren ? dmemload : (op_sc ? 32'd1 : 32'd0);
                  end else begin
                     e_stall = 1;
                  end
               end
            end
            e_wb = !e_stall && !ext_stall;
            chk("m_ren", dmemREN, e_ren);
            chk("m_wen", dmemWEN, e_wen);
            chk("m_stall", mem_stall, e_stall);
            chk("m_wb", memwb_EN, e_wb);
            chk("m_res", mem_result, e_res);
            chk("m_addr", dmemaddr, op_addr);
            chk("m_store", dmemstore, op_store);
            chk("m_halt", halt_out, m_halt);
            chk("m_mis", misalign_err, m_mis);
            chk("m_cnt", stall_cycles, m_cnt);
            if (e_done) m_res = e_res;
            m_served = m_served ? ext_stall : (e_done && ext_stall);
            if (op_halt && op_valid && !e_stall) m_halt = 1;
            if (e_mis) m_mis = 1;
            if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (e_done && !e_mis && op_ren && op_ll) begin
               m_lv = 1; m_la = op_addr;
            end else if ((e_done && !e_mis && op_wen && op_sc) ||
                         (snoop_inv && snoop_addr[31:2] == m_la[31:2])) begin
               m_lv = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic set_op(input logic ren, input logic wen, input logic ll, input logic sc,
                         input logic [31:0] addr, input logic [31:0] data);
      op_valid = 1; op_ren = ren; op_wen = wen; op_ll = ll; op_sc = sc; op_halt = 0;
      op_addr = addr; op_store = data;
   endtask

   task automatic clr_op();
      op_valid = 0; op_ren = 0; op_wen = 0; op_ll = 0; op_sc = 0; op_halt = 0;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #3;
      chk("rst_ren", dmemREN, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_res", mem_result, 0);
      chk("rst_cnt", stall_cycles, 0);
      step(); RST = 0;

      // LW 0x100, dhit on the fourth request cycle
      step(); set_op(1, 0, 0, 0, 32'h100, 0); dhit = 0;
      cnt_a = 0;
      for (int i = 0; i < 3; i++) begin
         #2; if (dmemREN && mem_stall) cnt_a++;
         step();
      end
      dhit = 1; dmemload = 32'hDEADBEEF; #2;
      chk("lw_wb", memwb_EN, 1);
      chk("lw_res", mem_result, 32'hDEADBEEF);
      chk("lw_ren_stall_cycles", cnt_a, 3);
      step(); clr_op(); dhit = 1; #2;
      chk("lw_stall_cnt", stall_cycles, 3);
      chk("idle_dhit_ren", dmemREN, 0);

      // LL then SC succeeds; second SC fails without a request
      step(); set_op(1, 0, 1, 0, 32'h200, 0); dhit = 1; dmemload = 32'h12345678; #2;
      chk("ll_res", mem_result, 32'h12345678);
      chk("ll_stall", mem_stall, 0);
      step(); set_op(0, 1, 0, 1, 32'h200, 32'h5); dhit = 1; #2;
      chk("sc_wen", dmemWEN, 1);
      chk("sc_res", mem_result, 1);
      step(); dhit = 0; #2;
      chk("sc2_wen", dmemWEN, 0);
      chk("sc2_res", mem_result, 0);
      chk("sc2_stall", mem_stall, 0);
      chk("sc2_wb", memwb_EN, 1);

      // Snoop to a neighbouring word leaves the link; snoop to the linked word kills it
      step(); set_op(1, 0, 1, 0, 32'h200, 0); dhit = 1;
      step(); clr_op(); dhit = 0; snoop_inv = 1; snoop_addr = 32'h204;
      step(); snoop_inv = 0; set_op(0, 1, 0, 1, 32'h200, 32'h7); dhit = 1; #2;
      chk("sn1_wen", dmemWEN, 1);
      chk("sn1_res", mem_result, 1);
      step(); set_op(1, 0, 1, 0, 32'h200, 0); dhit = 1;
      step(); clr_op(); dhit = 0; snoop_inv = 1; snoop_addr = 32'h200;
      step(); snoop_inv = 0; set_op(0, 1, 0, 1, 32'h200, 32'h9); dhit = 1; #2;
      chk("sn2_wen", dmemWEN, 0);
      chk("sn2_res", mem_result, 0);

      // Snoop hitting the link while an SC waits for dhit
      step(); set_op(1, 0, 1, 0, 32'h300, 0); dhit = 1;
      step(); set_op(0, 1, 0, 1, 32'h300, 32'h11); dhit = 0; #2;
      chk("sca_wen", dmemWEN, 1);
      chk("sca_stall", mem_stall, 1);
      step(); snoop_inv = 1; snoop_addr = 32'h300; #2;
      chk("sca_wen2", dmemWEN, 1);
      step(); snoop_inv = 0; #2;
      chk("sca_wen3", dmemWEN, 0);
      chk("sca_res", mem_result, 0);
      chk("sca_stall3", mem_stall, 0);

      // SW completing under ext_stall for two cycles
      step(); set_op(0, 1, 0, 0, 32'h400, 32'hA5); dhit = 1; ext_stall = 1;
      cnt_a = 0;
      #2; cnt_a += int'(dmemWEN);
      chk("sw_wb", memwb_EN, 0);
      step(); #2; cnt_a += int'(dmemWEN);
      chk("sw_wb2", memwb_EN, 0);
      chk("sw_stall2", mem_stall, 0);
      step(); ext_stall = 0; dhit = 0; #2; cnt_a += int'(dmemWEN);
      chk("sw_wb3", memwb_EN, 1);
      chk("sw_wen_once", cnt_a, 1);

      // Reset while a load waits; link must be gone afterwards
      step(); set_op(1, 0, 1, 0, 32'h600, 0); dhit = 1;
      step(); set_op(1, 0, 0, 0, 32'h500, 0); dhit = 0; #2;
      chk("ra_ren", dmemREN, 1);
      RST = 1; #1;
      chk("ra_ren0", dmemREN, 0);
      chk("ra_stall0", mem_stall, 0);
      chk("ra_res0", mem_result, 0);
      chk("ra_cnt0", stall_cycles, 0);
      step(); RST = 0; set_op(1, 0, 0, 0, 32'h700, 0); dhit = 1; dmemload = 32'hCAFEF00D; #2;
      chk("rb_ren", dmemREN, 1);
      chk("rb_res", mem_result, 32'hCAFEF00D);
      chk("rb_wb", memwb_EN, 1);
      step(); set_op(0, 1, 0, 1, 32'h600, 32'h3); dhit = 1; #2;
      chk("rb_sc_wen", dmemWEN, 0);
      chk("rb_sc_res", mem_result, 0);

      // Misaligned load, then halt blocks further requests
      step(); set_op(1, 0, 0, 0, 32'h102, 0); dhit = 0; dmemload = 32'h55555555; #2;
      chk("mis_ren", dmemREN, 0);
      chk("mis_res", mem_result, 0);
      chk("mis_stall", mem_stall, 0);
      step(); clr_op(); #2;
      chk("mis_err", misalign_err, 1);
      step(); op_valid = 1; op_halt = 1;
      step(); clr_op(); #2;
      chk("halt_set", halt_out, 1);
      step(); set_op(1, 0, 0, 0, 32'h100, 0); #2;
      chk("halt_ren", dmemREN, 0);
      chk("halt_stall", mem_stall, 0);
      step(); clr_op();
      step();
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
